// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and data_mem.
// Accepts one request per req_valid/req_ready handshake, rejects illegal or
// misaligned requests without touching memory, otherwise drives data_mem for
// exactly one cycle and returns the (already extended) load data through a
// resp_valid/resp_ready channel.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3              store flag, RV32I width/sign code
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            load result (0 for stores/errors), error flag
//   mem_wr_en, mem_funct3           data_mem write enable and width code
//   mem_addr, mem_wdata             data_mem address and write data
//   mem_rd_data                     data_mem combinational, extended read data
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state;
   logic   cap_we;
   logic   illegal_c;
   logic   misaligned_c;

   // Classify the incoming request from the live req_* inputs.
   always_comb begin
      illegal_c    = 1'b0;
      misaligned_c = 1'b0;
      if (req_we) begin
         illegal_c = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                     (req_funct3 != 3'b010);
      end else begin
         illegal_c = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
      end
      if (req_funct3[1:0] == 2'b01) begin
         misaligned_c = req_addr[0];
      end else if (req_funct3[1:0] == 2'b10) begin
         misaligned_c = (req_addr[1:0] != 2'b00);
      end
   end

   // Request/access/response sequencing with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cap_we     <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_wr_en  <= 1'b0;
         mem_funct3 <= 3'b000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we     <= req_we;
                  mem_funct3 <= req_funct3;
                  mem_addr   <= req_addr;
                  mem_wdata  <= req_wdata;
                  req_ready  <= 1'b0;
                  if (illegal_c || misaligned_c) begin
                     // Bad requests skip ACCESS so memory is never touched.
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state     <= ACCESS;
                     mem_wr_en <= req_we;
                  end
               end
            end
            ACCESS: begin
               state      <= RESP;
               mem_wr_en  <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= cap_we ? '0 : mem_rd_data;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               mem_wr_en  <= 1'b0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a byte-array data_mem stand-in drives the
// memory side, and a separate byte-array reference model predicts every
// response, error flag and write count from the request rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_wr_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rd_data;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_count = 0;

   logic [7:0] dm      [256];
   logic [7:0] ref_mem [256];

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_wr_en  (mem_wr_en),
      .mem_funct3 (mem_funct3),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd_data(mem_rd_data)
   );

   // data_mem stand-in: combinational extended read, byte-lane write on clk.
   logic [7:0] b0, b1, b2, b3;
   always_comb begin
      b0 = dm[mem_addr[7:0]];
      b1 = dm[8'(mem_addr[7:0] + 8'd1)];
      b2 = dm[8'(mem_addr[7:0] + 8'd2)];
      b3 = dm[8'(mem_addr[7:0] + 8'd3)];
      case (mem_funct3)
         3'b000:  mem_rd_data = {{24{b0[7]}}, b0};
         3'b001:  mem_rd_data = {{16{b1[7]}}, b1, b0};
         3'b010:  mem_rd_data = {b3, b2, b1, b0};
         3'b100:  mem_rd_data = {24'h0, b0};
         3'b101:  mem_rd_data = {16'h0, b1, b0};
         default: mem_rd_data = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wr_count <= wr_count + 1;
         dm[mem_addr[7:0]] <= mem_wdata[7:0];
         if (mem_funct3[1:0] != 2'b00) dm[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            dm[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
            dm[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: size = 2^funct3[1:0] bytes, little-endian, modulo-256 memory.
   function automatic void model_req(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rd);
      int     n;
      bit     legal;
      longint v;
      n     = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      err   = !legal || ((addr % n) != 0);
      rd    = '0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++)
               ref_mem[int'((addr + 32'(i)) % 256)] = 8'(wdata >> (8 * i));
         end else begin
            v = 0;
            for (int i = 0; i < n; i++)
               v = v + (longint'(ref_mem[int'((addr + 32'(i)) % 256)]) << (8 * i));
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
               v = v - (longint'(1) << (8 * n));
            rd = 32'(v);
         end
      end
   endfunction

   // Issue one request, hold resp_ready low for 'delay' cycles, check everything.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input string name);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          w0, lat, tries, exp_lat, exp_w;
      bit          acc;
      model_req(we, f3, addr, wdata, exp_err, exp_rd);
      exp_lat = exp_err ? 1 : 2;
      exp_w   = (we && !exp_err) ? 1 : 0;
      w0      = wr_count;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      acc = 1'b0; tries = 0;
      while (!acc && tries < 20) begin
         acc = req_ready;
         tick();
         tries++;
      end
      req_valid = 1'b0;
      n_checks++;
      if (!acc) $display("FAIL %s_accept: req_ready never seen high", name);
      else n_pass++;
      resp_ready = (delay == 0);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== exp_lat) $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, exp_lat);
      else n_pass++;
      for (int k = 0; k < delay; k++) begin
         n_checks++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== exp_rd || resp_err !== exp_err)
            $display("FAIL %s_hold%0d: valid=%b ready=%b rdata=%h err=%b, expected 1 0 %h %b",
                     name, k, resp_valid, req_ready, resp_rdata, resp_err, exp_rd, exp_err);
         else n_pass++;
         tick();
      end
      resp_ready = 1'b1;
      n_checks++;
      if (resp_rdata !== exp_rd) $display("FAIL %s_rdata: got %h, expected %h", name, resp_rdata, exp_rd);
      else n_pass++;
      n_checks++;
      if (resp_err !== exp_err) $display("FAIL %s_err: got %b, expected %b", name, resp_err, exp_err);
      else n_pass++;
      tick();
      resp_ready = 1'b0;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL %s_release: valid=%b ready=%b, expected 0 1", name, resp_valid, req_ready);
      else n_pass++;
      n_checks++;
      if (wr_count - w0 !== exp_w)
         $display("FAIL %s_writes: got %0d, expected %0d", name, wr_count - w0, exp_w);
      else n_pass++;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
          mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b000)
         $display("FAIL reset_values: ready=%b valid=%b err=%b rdata=%h wr=%b addr=%h",
                  req_ready, resp_valid, resp_err, resp_rdata, mem_wr_en, mem_addr);
      else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_word();
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw_10");
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10");
   endtask

   task automatic test_byte_half();
      do_req(1'b1, 3'b000, 32'h11, 32'h00000080, 0, "sb_11");
      do_req(1'b0, 3'b000, 32'h11, 32'h0, 0, "lb_11");
      do_req(1'b0, 3'b100, 32'h11, 32'h0, 0, "lbu_11");
      do_req(1'b0, 3'b101, 32'h12, 32'h0, 0, "lhu_12");
   endtask

   task automatic test_misaligned();
      do_req(1'b0, 3'b010, 32'h06, 32'h0, 0, "lw_06");
      do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0, "sh_03");
      do_req(1'b0, 3'b001, 32'h05, 32'h0, 0, "lh_05");
   endtask

   task automatic test_illegal();
      do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, "st_f3_100");
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, "ld_f3_011");
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_illegal");
   endtask

   task automatic test_backpressure();
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, "lw_stall");
   endtask

   task automatic test_reset_in_access();
      int w0;
      w0 = wr_count;
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (mem_wr_en !== 1'b1) $display("FAIL rst_access_entry: mem_wr_en=%b, expected 1", mem_wr_en);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wr_en !== 1'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0)
         $display("FAIL rst_access_outputs: ready=%b valid=%b wr=%b addr=%h wdata=%h",
                  req_ready, resp_valid, mem_wr_en, mem_addr, mem_wdata);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (wr_count !== w0) $display("FAIL rst_access_nowrite: got %0d writes, expected 0", wr_count - w0);
      else n_pass++;
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw_20_after_rst");
   endtask

   task automatic test_random();
      logic        we;
      logic [2:0]  f3;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         do_req(we, f3, 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3), "rand");
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dm[i]      = 8'($urandom);
         ref_mem[i] = dm[i];
      end
      test_reset();
      test_word();
      test_byte_half();
      test_misaligned();
      test_illegal();
      test_backpressure();
      test_reset_in_access();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
